// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter that time-shares one multi-cycle floating-point adder among N_REQ requesters.
// Each operation runs LOAD -> RUN (WINDOW cycles) -> RESP; the adder's one-cycle result is OR-captured.
module fpadd_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned WINDOW = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  busy,
    output logic [31:0]           fpa_a,
    output logic [31:0]           fpa_b,
    output logic                  fpa_reset,
    input  logic [31:0]           fpa_s
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} state_e;

    state_e              state_q;
    logic [IdxW-1:0]     last_grant_q;
    logic [IdxW-1:0]     grant_q;
    logic [CntW-1:0]     cnt_q;
    logic [31:0]         acc_q;

    logic [IdxW-1:0]     win_idx;
    logic                win_found;
    logic [N_REQ-1:0]    win_onehot;
    logic [N_REQ-1:0]    grant_onehot;
    logic [31:0]         a_sel;
    logic [31:0]         b_sel;
    logic                handshake;

    // Search starts one past the previous winner so every requester is served in turn.
    always_comb begin
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand     = (32'(last_grant_q) + 32'd1 + k) % N_REQ;
            cand_idx = IdxW'(cand);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_onehot   = '0;
        grant_onehot = '0;
        win_onehot[win_idx]   = 1'b1;
        grant_onehot[grant_q] = 1'b1;
    end

    assign req_ready = (state_q == StIdle && reset && win_found) ? win_onehot : '0;
    assign handshake = |(req_valid & req_ready);
    assign a_sel     = req_a[32*win_idx +: 32];
    assign b_sel     = req_b[32*win_idx +: 32];
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= IdxW'(N_REQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            fpa_a        <= '0;
            fpa_b        <= '0;
            fpa_reset    <= 1'b1;
            rsp_valid    <= '0;
            rsp_data     <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        state_q      <= StLoad;
                        last_grant_q <= win_idx;
                        grant_q      <= win_idx;
                        fpa_a        <= a_sel;
                        fpa_b        <= b_sel;
                    end
                end
                StLoad: begin
                    state_q   <= StRun;
                    fpa_reset <= 1'b0;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                end
                StRun: begin
                    // The adder drives nonzero only in its finish cycle, so OR is an exact capture.
                    acc_q <= acc_q | fpa_s;
                    if (cnt_q == CntW'(WINDOW - 1)) begin
                        state_q   <= StResp;
                        cnt_q     <= '0;
                        rsp_valid <= grant_onehot;
                        rsp_data  <= acc_q | fpa_s;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    state_q   <= StIdle;
                    fpa_reset <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter: a behavioural adder stub on the fpa_* ports, a timestamp-level
// model of the arbiter checked every cycle, directed literal cases and a randomized phase.
module tb_fpadd_arbiter;

    localparam int N = 4;
    localparam int W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [32*N-1:0]   req_a = '0;
    logic [32*N-1:0]   req_b = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_data;
    logic              busy;
    logic [31:0]       fpa_a;
    logic [31:0]       fpa_b;
    logic              fpa_reset;
    logic [31:0]       fpa_s;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpadd_arbiter #(.N_REQ(N), .WINDOW(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .fpa_a     (fpa_a),
        .fpa_b     (fpa_b),
        .fpa_reset (fpa_reset),
        .fpa_s     (fpa_s)
    );

    // Exact single <-> double conversions for normal numbers and zero.
    function automatic real f2r(logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(logic [31:0] a, logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Quarter-step values in [-500, 500] keep every sum exactly representable.
    function automatic logic [31:0] rand_fp();
        int i;
        i = int'($urandom_range(0, 4000)) - 2000;
        return r2f(real'(i) / 4.0);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Adder stub: result appears for exactly one cycle, RUN cycle 4 or 5.
    int add_cyc = 0;
    int fin_at  = 3;
    always @(posedge clk) begin
        if (fpa_reset) begin
            add_cyc <= 0;
            fin_at  <= 3 + int'($urandom_range(0, 1));
        end else if (add_cyc < 100) begin
            add_cyc <= add_cyc + 1;
        end
    end
    always_comb begin
        fpa_s = 32'h0;
        if (!fpa_reset && add_cyc == fin_at) fpa_s = fp_add(fpa_a, fpa_b);
    end

    // Transaction model: one op in flight, tracked by its phase since the handshake.
    bit          check_en = 1'b0;
    bit          m_active = 1'b0;
    int          m_ph = 0;
    int          m_g = 0;
    int          m_last = N - 1;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_sum = '0;
    logic [N-1:0] hs_seen = '0;
    logic [31:0] fin_s_seen = '0;

    always @(negedge clk) begin
        int w;
        logic [N-1:0] er;
        logic [N-1:0] ers;
        if (!fpa_reset && add_cyc == fin_at) fin_s_seen = fpa_s;
        if (check_en) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_last + 1 + k) % N;
                if (w < 0 && req_valid[c]) w = c;
            end
            er = '0;
            if (!m_active && reset && w >= 0) er[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("busy", 32'(busy), 32'(m_active));
            chk("fpa_reset", 32'(fpa_reset), 32'(!(m_active && m_ph >= 2)));
            ers = '0;
            if (m_active && m_ph == W + 2) ers[m_g] = 1'b1;
            chk("rsp_valid", 32'(rsp_valid), 32'(ers));
            if (ers != '0) chk("rsp_data", rsp_data, m_sum);
            if (m_active) begin
                chk("fpa_a", fpa_a, m_a);
                chk("fpa_b", fpa_b, m_b);
            end
            hs_seen = req_valid & req_ready & {N{reset}};
            if (!reset) begin
                m_active = 1'b0;
                m_last   = N - 1;
            end else if (m_active) begin
                if (m_ph == W + 2) m_active = 1'b0;
                else m_ph++;
            end else if (w >= 0) begin
                m_active = 1'b1;
                m_ph     = 1;
                m_g      = w;
                m_last   = w;
                m_a      = req_a[32*w +: 32];
                m_b      = req_b[32*w +: 32];
                m_sum    = fp_add(m_a, m_b);
            end
        end
    end

    task automatic do_op(int idx, logic [31:0] a, logic [31:0] b, logic [N-1:0] ev,
                         logic [31:0] ed);
        int t;
        bit got;
        @(posedge clk); #1;
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_valid[idx] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1'b1;
        end
        chk("grant_seen", 32'(got), 32'd1);
        t = cyc;
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) got = 1'b1;
        end
        chk("rsp_seen", 32'(got), 32'd1);
        chk("latency", 32'(cyc - t), 32'(W + 2));
        chk("rsp_valid_lit", 32'(rsp_valid), 32'(ev));
        chk("rsp_data_lit", rsp_data, ed);
        chk("hold_a", fpa_a, a);
        chk("hold_b", fpa_b, b);
        chk("adder_finish", rsp_data, fin_s_seen);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gi[$];
        int gt[$];
        bit got;
        int t;

        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_fpa_a", fpa_a, 32'h0);
        chk("reset_fpa_b", fpa_b, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);

        do_op(0, 32'h3F80_0000, 32'h3F80_0000, 4'b0001, 32'h4000_0000);
        do_op(2, 32'h3FC0_0000, 32'h4020_0000, 4'b0100, 32'h4080_0000);
        do_op(1, 32'h4040_0000, 32'hBF80_0000, 4'b0010, 32'h4000_0000);
        do_op(3, 32'h3F80_0000, 32'hBF80_0000, 4'b1000, 32'h0000_0000);

        // All requesters held valid straight out of reset.
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = rand_fp();
            req_b[32*i +: 32] = rand_fp();
        end
        req_valid = '1;
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    gi.push_back(i);
                    gt.push_back(cyc);
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("rr_count", 32'(gi.size()), 32'd5);
        for (int k = 0; k < gi.size(); k++) begin
            chk("rr_order", 32'(gi[k]), 32'(k % N));
            if (k > 0) chk("rr_spacing", 32'(gt[k] - gt[k-1]), 32'(W + 3));
        end
        repeat (12) @(posedge clk);

        // Reset during RUN cycle 3 aborts the operation.
        #1;
        req_a[32*1 +: 32] = 32'h4000_0000;
        req_b[32*1 +: 32] = 32'h4040_0000;
        req_valid[1] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        chk("abort_grant_seen", 32'(got), 32'd1);
        t = cyc;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_cycle", 32'(cyc - t), 32'd4);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_fpa_reset", 32'(fpa_reset), 32'd1);
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) got = 1'b1;
        end
        chk("abort_no_rsp", 32'(got), 32'd0);
        do_op(1, 32'h4040_0000, 32'hBF80_0000, 4'b0010, 32'h4000_0000);

        // Randomized traffic with retractions and occasional reset pulses.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 199) == 0) reset = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (hs_seen[i]) begin
                    req_valid[i] = 1'b0;
                    if ($urandom_range(0, 1) == 0) begin
                        req_a[32*i +: 32] = rand_fp();
                        req_b[32*i +: 32] = rand_fp();
                        req_valid[i] = 1'b1;
                    end
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_a[32*i +: 32] = rand_fp();
                        req_b[32*i +: 32] = rand_fp();
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpadd_arbiter.md
FPADD_ARBITER -- requirements
Module: fpadd_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one adder (2..8).
REQ-002 Parameter WINDOW, default 6, run-phase length in cycles; SHALL be 5..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; one clock; reset is synchronous and active-low.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_a, req_b  input  32*N_REQ  per-requester IEEE-754 single operands, slice i = bits [32i+31:32i].
REQ-007 req_ready  output  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-008 rsp_valid  output  N_REQ  one-hot, one-cycle result strobe to the granted requester.
REQ-009 rsp_data  output  32  sum, valid only while rsp_valid != 0.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 fpa_a, fpa_b  output  32  registered operands to the adder (point_floating a/b).
REQ-012 fpa_reset  output  1  registered, active-high, drives the adder's reset.
REQ-013 fpa_s  input  32  adder result (point_floating s2); nonzero only in the adder's finish cycle.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, RESP; IDLE -> LOAD on handshake, LOAD -> RUN after 1 cycle, RUN -> RESP after WINDOW cycles, RESP -> IDLE after 1 cycle.
REQ-015 req_ready SHALL be nonzero only in IDLE, combinationally one-hot on the winning requester; zero when no req_valid.
REQ-016 Arbitration round-robin: search starts at last_grant+1 modulo N_REQ; last_grant updates only on handshake.
REQ-017 On handshake, the granted index, req_a slice and req_b slice SHALL be latched; fpa_a/fpa_b take them at the same edge and hold through RESP.
REQ-018 fpa_reset SHALL be 1 in IDLE and LOAD, 0 in RUN and RESP; the adder therefore starts from its first state in RUN cycle 1.
REQ-019 Accumulator cleared on entry to RUN; each RUN cycle acc <= acc | fpa_s; capture by OR is exact because the adder's finish occurs exactly once within RUN cycles 4..5 and the next finish is no earlier than RUN cycle 9.
REQ-020 In RESP: rsp_valid[grant] = 1, rsp_data = acc, one cycle, no backpressure; a zero sum is returned as 0x00000000.
REQ-021 Latency: handshake at edge ending cycle T -> LOAD cycle T+1, RUN T+2..T+1+WINDOW, RESP T+2+WINDOW (T+8 at default).
REQ-022 Throughput: one operation per WINDOW+3 cycles; a pending request can be granted in the IDLE cycle right after RESP.
REQ-023 Requests arriving while busy SHALL be held off (req_ready = 0); requester must keep req_valid and operands stable until granted.
REQ-024 req_valid deasserted before grant SHALL not be granted; no request is lost or duplicated.
REQ-025 Counter width SHALL be ceil(log2(WINDOW+1)); counter wraps to 0 when leaving RUN.
REQ-026 Simultaneous requests: exactly one grant per IDLE cycle, chosen per REQ-016.

Reset
REQ-027 When reset = 0 at a rising edge: state IDLE, last_grant = N_REQ-1 (requester 0 wins first), acc = 0, fpa_a = fpa_b = 0, fpa_reset = 1, busy = 0, rsp_valid = 0, rsp_data = 0.
REQ-028 Reset in LOAD/RUN/RESP SHALL abort the operation: no rsp_valid for it, adder held reset from the next cycle.
REQ-029 req_ready SHALL be 0 in any cycle where reset = 0.

Verification (bench instantiates point_floating on the fpa_* ports)
REQ-030 Req0 a=0x3F800000 b=0x3F800000 at T -> rsp_valid=0001, rsp_data=0x40000000 at T+8; busy high T+1..T+8.
REQ-031 Req2 a=0x3FC00000 b=0x40200000 -> rsp_valid=0100, rsp_data=0x40800000, fpa_a/fpa_b constant through RESP.
REQ-032 Req1 a=0x40400000 b=0xBF800000 (different signs) -> rsp_data=0x40000000 at T+8.
REQ-033 All four req_valid held high for 40 cycles after reset -> grants 0,1,2,3,0 at 9-cycle spacing, rsp order identical.
REQ-034 reset=0 during RUN cycle 3 of a request -> no rsp_valid, busy=0 and fpa_reset=1 next cycle, next request completes normally.
REQ-035 Req3 a=0x3F800000 b=0xBF800000 -> rsp_valid=1000 at T+8 with rsp_data equal to the adder's finish-cycle output (cross-checked against the adder alone).
